// File: rtl/mux_arb_n.sv
// ---------------------------------------------------------------------------------------------
// mux_arb_n
//
// Purpose
//   N-channel valid/ready multiplexer with a single registered output stage. Channel selection
//   is either directed (mode=0, channel chosen by Sel) or round-robin (mode=1, search starts
//   one past the last channel granted in round-robin mode). One word per cycle is sustained
//   when the downstream keeps out_ready high.
//
// Ports
//   Clk        in   1         rising-edge clock
//   Reset      in   1         asynchronous, active-high reset
//   mode       in   1         0 = directed select, 1 = round-robin
//   Sel        in   SW        channel index for mode=0 (values >= N select nothing)
//   in_valid   in   N         per-channel valid
//   in_data    in   N*WIDTH   channel i at [i*WIDTH +: WIDTH]
//   in_ready   out  N         per-channel accept strobe (one-hot or zero)
//   out_valid  out  1         output register holds a word
//   out_data   out  WIDTH     registered word
//   out_src    out  SW        channel that supplied out_data
//   out_ready  in   1         downstream accept
//   xfer_cnt   out  16        saturating count of output transfers (only with the macro below)
//
// Configuration
//   MUX_ARB_N_XFER_CNT_EN  when defined, adds the xfer_cnt port and its counter.
// ---------------------------------------------------------------------------------------------
module mux_arb_n #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4,
    localparam int unsigned SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 mode,
    input  logic [SW-1:0]        Sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_src,
`ifdef MUX_ARB_N_XFER_CNT_EN
    output logic [15:0]          xfer_cnt,
`endif
    input  logic                 out_ready
);

    // Channel count as an SW+1 bit value so Sel can be range-checked without truncation.
    localparam logic [SW:0] NVal = (SW + 1)'(N);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_src_q, out_src_d;
    logic [SW-1:0]    rr_ptr_q, rr_ptr_d;

    logic             load;
    logic             grant_vld;
    logic [SW-1:0]    grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             capture;

    // -----------------------------------------------------------------------------------------
    // Grant decision
    // -----------------------------------------------------------------------------------------
    always_comb begin
        int cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        if (!mode) begin
            if (({1'b0, Sel} < NVal) && in_valid[Sel]) begin
                grant_vld = 1'b1;
                grant_idx = Sel;
            end
        end else begin
            // Scan (rr_ptr+1) .. (rr_ptr+N) modulo N; the last candidate is rr_ptr itself so a
            // lone requester that was just served still wins again.
            for (int k = 1; k <= int'(N); k++) begin
                cand = (32'(rr_ptr_q) + k) % int'(N);
                if (!grant_vld && in_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand[SW-1:0];
                end
            end
        end
    end

    // Word of the granted channel.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (grant_idx == SW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // The register can take a new word when it is empty or is being drained this cycle.
    assign load    = (state_q == StEmpty) || out_ready;
    assign capture = load && grant_vld;

    // Accept strobe only for the granted channel; suppressed while reset is held so nothing
    // is consumed upstream that the output stage is about to discard.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (capture && !Reset && (grant_idx == SW'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Output-stage FSM: state register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Output-stage FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (capture) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                // Draining with nothing to refill empties the stage; a refill keeps it full.
                if (out_ready && !grant_vld) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Output-stage FSM: outputs
    always_comb begin
        out_valid = (state_q == StFull);
    end

    // -----------------------------------------------------------------------------------------
    // Data path registers
    // -----------------------------------------------------------------------------------------
    always_comb begin
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        rr_ptr_d   = rr_ptr_q;
        if (capture) begin
            out_data_d = grant_data;
            out_src_d  = grant_idx;
            // Directed captures do not disturb round-robin fairness.
            if (mode) begin
                rr_ptr_d = grant_idx;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_data_q <= '0;
            out_src_q  <= '0;
            // Pointer at N-1 makes channel 0 the first round-robin winner.
            rr_ptr_q   <= SW'(N - 1);
        end else begin
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign out_data = out_data_q;
    assign out_src  = out_src_q;

`ifdef MUX_ARB_N_XFER_CNT_EN
    // -----------------------------------------------------------------------------------------
    // Saturating transfer counter
    // -----------------------------------------------------------------------------------------
    logic [15:0] xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (out_valid && out_ready && (xfer_cnt_q != 16'hFFFF)) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: doc/mux_arb_n.md
MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 Parameter WIDTH, default 16: data width of every input channel and of the output, in bits.
REQ-002 Parameter N, default 4: number of input channels, 2..16; SW = $clog2(N).
REQ-003 Clk  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 mode  input  1  0 = directed select via Sel; 1 = round-robin arbitration.
REQ-006 Sel  input  SW  channel index used when mode=0; values >= N select no channel.
REQ-007 in_valid  input  N  per-channel data-valid flag.
REQ-008 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_ready  output  N  per-channel accept strobe; transfer on channel i when in_valid[i] && in_ready[i].
REQ-010 out_valid  output  1  output register holds a word.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_src  output  SW  index of the channel that supplied out_data.
REQ-013 out_ready  input  1  downstream accepts the word when out_valid && out_ready.

Function
REQ-014 Output stage SHALL be a single register with two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 load = !out_valid || out_ready; new word captured only on a cycle where load=1 and a grant exists.
REQ-016 mode=0: grant = Sel when Sel < N and in_valid[Sel]=1; otherwise no grant.
REQ-017 mode=1: grant = first channel with in_valid set, searching from (rr_ptr+1) mod N upward with wrap-around.
REQ-018 in_ready[g] = load for the granted channel g only; all other in_ready bits 0; in_ready combinational, in_valid SHALL NOT depend on in_ready.
REQ-019 On capture: out_data <= granted word, out_src <= g, out_valid <= 1, in the same Clk edge (latency 1 cycle input to output).
REQ-020 out_valid && out_ready with no grant: out_valid <= 0 next edge (FULL -> EMPTY).
REQ-021 out_valid && out_ready with a grant: back-to-back capture, out_valid stays 1, one word per cycle sustained.
REQ-022 out_valid && !out_ready: out_data, out_src, out_valid held; all in_ready 0.
REQ-023 rr_ptr <= g on every capture in mode=1 only; mode=0 captures leave rr_ptr unchanged.
REQ-024 mode or Sel change takes effect on the same cycle's grant decision; held output word unaffected.
REQ-025 N=2, mode=0, out_ready tied 1 SHALL reproduce a registered 2:1 select of Sel channel.

Reset
REQ-026 Reset=1 SHALL immediately force out_valid=0, out_data=0, out_src=0, rr_ptr=N-1 (channel 0 wins first round-robin).
REQ-027 Reset asserted mid-transfer SHALL discard the held word; no transfer occurs while Reset=1 (in_ready all 0).

Configuration
REQ-028 Macro MUX_ARB_N_XFER_CNT_EN defined: extra output xfer_cnt [15:0] counts output transfers (out_valid && out_ready), saturating at 16'hFFFF, reset to 0.
REQ-029 Macro undefined: port xfer_cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset pulse mid-operation with out_valid=1 -> out_valid=0, out_data=0, out_src=0 before next Clk edge.
REQ-031 mode=0, N=4, Sel=2, in_valid=4'b0100, in_data[2]=16'h0007, out_ready=1 -> next edge out_data=16'h0007, out_src=2; Sel=3 with in_valid[3]=0 -> no grant, out_valid=0 after next edge.
REQ-032 mode=1, in_valid=4'b1111 constant, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 mode=1, in_valid=4'b1010, out_ready=1 -> out_src alternates 1,3,1; wrap from 3 to 1 skips 0 and 2.
REQ-034 out_ready=0 for 3 cycles with out_data=16'h000F -> out_data/out_src held, in_ready=0; out_ready=1 -> next word loaded same edge.
REQ-035 MUX_ARB_N_XFER_CNT_EN defined, 5 completed transfers plus 2 stalled cycles -> xfer_cnt=5.
